// File: rtl/ea4163_vme_pkg.sv
// Shared constants and types for the EA4163 VME A16/D16 slave interface.
package ea4163_vme_pkg;

  localparam int unsigned VME_A_W    = 15;
  localparam int unsigned VME_AM_W   = 6;
  localparam int unsigned VME_D_W    = 16;
  localparam int unsigned REG_ADDR_W = 8;
  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_BE_W   = 2;
  localparam int unsigned TMO_W      = 8;

  localparam logic [VME_AM_W-1:0] AM_A16_SUP = 6'h2D;
  localparam logic [VME_AM_W-1:0] AM_A16_USR = 6'h29;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_ACK,
    DTACK,
    RELEASE,
    IGNORE
  } state_t;

endpackage

// File: rtl/vme_sync.sv
// N-stage synchroniser for asynchronous active-low VME strobes; resets to the inactive level.
module vme_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift chain, loaded with 1 so strobes read as inactive out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/vme_slave_ctrl.sv
// VME A16/D16 slave cycle sequencer: turns each accepted VME cycle into one
// local register-bus strobe and drives DTACK* and the read-data enable.
module vme_slave_ctrl
  import ea4163_vme_pkg::*;
#(
  parameter logic [15:0]         BASE_ADDR   = 16'hA000,
  parameter logic [15:0]         ADDR_MASK   = 16'hFF00,
  parameter logic [VME_AM_W-1:0] AM_SUP      = AM_A16_SUP,
  parameter logic [VME_AM_W-1:0] AM_USR      = AM_A16_USR,
  parameter logic [TMO_W-1:0]    ACK_TIMEOUT = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vme_as,
  input  logic                  vme_ds0,
  input  logic                  vme_ds1,
  input  logic                  vme_wr,
  input  logic                  vme_lword,
  input  logic [VME_A_W-1:0]    vme_a,
  input  logic [VME_AM_W-1:0]   vme_am,
  input  logic [VME_D_W-1:0]    vme_d,
  output logic [VME_D_W-1:0]    vme_rdata,
  output logic                  vme_d_oe,
  output logic                  vme_dtack_d,
  output logic                  vme_dtack_en,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [REG_DATA_W-1:0] reg_wdata,
  output logic [REG_BE_W-1:0]   reg_be,
  output logic                  reg_wr,
  output logic                  reg_rd,
  input  logic [REG_DATA_W-1:0] reg_rdata,
  input  logic                  reg_ack
);

  logic as_s, ds0_s, ds1_s, wr_s;

  vme_sync #(.STAGES(2)) u_sync_as  (.clk(clk), .rst_n(rst_n), .d(vme_as),  .q(as_s));
  vme_sync #(.STAGES(2)) u_sync_ds0 (.clk(clk), .rst_n(rst_n), .d(vme_ds0), .q(ds0_s));
  vme_sync #(.STAGES(2)) u_sync_ds1 (.clk(clk), .rst_n(rst_n), .d(vme_ds1), .q(ds1_s));
  vme_sync #(.STAGES(2)) u_sync_wr  (.clk(clk), .rst_n(rst_n), .d(vme_wr),  .q(wr_s));

  // Address and AM are only looked at in DECODE, when they are stable by bus rules
  logic am_hit, addr_hit, hit;
  assign am_hit   = (vme_am == AM_SUP) || (vme_am == AM_USR);
  assign addr_hit = (({vme_a, 1'b0} & ADDR_MASK) == BASE_ADDR);
  assign hit      = am_hit && vme_lword && addr_hit;

  state_t                state, state_nxt;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic                  is_rd, is_rd_nxt;
  logic [REG_ADDR_W-1:0] reg_addr_nxt;
  logic [REG_DATA_W-1:0] reg_wdata_nxt;
  logic [REG_BE_W-1:0]   reg_be_nxt;
  logic                  reg_wr_nxt, reg_rd_nxt;
  logic [VME_D_W-1:0]    vme_rdata_nxt;
  logic                  vme_d_oe_nxt, vme_dtack_d_nxt, vme_dtack_en_nxt;

  // State, timeout counter and all registered outputs; reset also kills the DTACK driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      is_rd        <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_be       <= '0;
      reg_wr       <= 1'b0;
      reg_rd       <= 1'b0;
      vme_rdata    <= '0;
      vme_d_oe     <= 1'b0;
      vme_dtack_d  <= 1'b1;
      vme_dtack_en <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      is_rd        <= is_rd_nxt;
      reg_addr     <= reg_addr_nxt;
      reg_wdata    <= reg_wdata_nxt;
      reg_be       <= reg_be_nxt;
      reg_wr       <= reg_wr_nxt;
      reg_rd       <= reg_rd_nxt;
      vme_rdata    <= vme_rdata_nxt;
      vme_d_oe     <= vme_d_oe_nxt;
      vme_dtack_d  <= vme_dtack_d_nxt;
      vme_dtack_en <= vme_dtack_en_nxt;
    end
  end

  // Cycle sequencing; bus-side outputs are derived from the state being entered
  always_comb begin
    state_nxt     = state;
    tmo_cnt_nxt   = tmo_cnt;
    is_rd_nxt     = is_rd;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    reg_be_nxt    = reg_be;
    reg_wr_nxt    = 1'b0;
    reg_rd_nxt    = 1'b0;
    vme_rdata_nxt = vme_rdata;

    unique case (state)
      IDLE: begin
        if (!as_s && (!ds0_s || !ds1_s)) begin
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (hit) begin
          reg_addr_nxt  = vme_a[REG_ADDR_W-1:0];
          reg_wdata_nxt = vme_d;
          reg_be_nxt    = {~ds1_s, ~ds0_s};
          is_rd_nxt     = wr_s;
          reg_wr_nxt    = !wr_s;
          reg_rd_nxt    = wr_s;
          tmo_cnt_nxt   = '0;
          state_nxt     = WAIT_ACK;
        end else begin
          state_nxt = IGNORE;
        end
      end
      WAIT_ACK: begin
        if (reg_ack) begin
          if (is_rd) begin
            vme_rdata_nxt = reg_rdata;
          end
          state_nxt = DTACK;
        end else if (tmo_cnt == ACK_TIMEOUT - TMO_W'(1)) begin
          state_nxt = IGNORE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      DTACK: begin
        if (ds0_s && ds1_s) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      IGNORE: begin
        if (as_s && ds0_s && ds1_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    vme_dtack_en_nxt = (state_nxt == DTACK) || (state_nxt == RELEASE);
    vme_dtack_d_nxt  = (state_nxt != DTACK);
    vme_d_oe_nxt     = (state_nxt == DTACK) && is_rd_nxt;
  end

endmodule
